// File: rtl/fifo_rd_ptr_if.sv
// Read-side bundle of an async FIFO: consumer handshake, pointer exchange with the
// empty-detect stage and write domain, and read-domain status flags.
interface fifo_rd_ptr_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  rd_en;
    logic                  rd_empty;
    logic [ADDR_WIDTH:0]   wr_ptr_gray;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH:0]   rd_ptr_gray;
    logic [ADDR_WIDTH:0]   wr_ptr_gray_sync;
    logic [ADDR_WIDTH:0]   rd_count;
    logic                  rd_almost_empty;
    logic                  rd_underflow;

    // The read-pointer block itself
    modport slave (
        input  rd_en, rd_empty, wr_ptr_gray,
        output rd_addr, rd_ptr_gray, wr_ptr_gray_sync, rd_count,
               rd_almost_empty, rd_underflow
    );

    // The consumer / surrounding FIFO logic
    modport master (
        output rd_en, rd_empty, wr_ptr_gray,
        input  rd_addr, rd_ptr_gray, wr_ptr_gray_sync, rd_count,
               rd_almost_empty, rd_underflow
    );
endinterface

// File: rtl/fifo_rd_ptr.sv
// Async FIFO read-pointer block: binary/Gray read pointer, write-pointer synchronizer,
// read-side fill level and almost-empty / underflow flags, all in the rd_clk domain.
module fifo_rd_ptr #(
    parameter int ADDR_WIDTH   = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AE_THRESHOLD = 2
) (
    input  logic          rd_clk,
    input  logic          rst_n,
    fifo_rd_ptr_if.slave  bus
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AE_LEVEL = PW'(AE_THRESHOLD);

    logic [PW-1:0] rd_ptr_bin_q, rd_ptr_bin_d;
    logic [PW-1:0] rd_ptr_gray_q, rd_ptr_gray_d;
    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] wr_ptr_bin_sync;
    logic [PW-1:0] rd_count_q, rd_count_d;
    logic          rd_almost_empty_q, rd_almost_empty_d;
    logic          rd_underflow_q, rd_underflow_d;
    logic          rd_fire;

    function automatic logic [PW-1:0] gray_to_bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Count and flags use the next-state pointer so they never lag the pointer itself.
    always_comb begin
        rd_fire           = bus.rd_en & ~bus.rd_empty;
        rd_ptr_bin_d      = rd_ptr_bin_q + {{ADDR_WIDTH{1'b0}}, rd_fire};
        rd_ptr_gray_d     = rd_ptr_bin_d ^ (rd_ptr_bin_d >> 1);
        wr_ptr_bin_sync   = gray_to_bin(sync_q[SYNC_STAGES-1]);
        rd_count_d        = wr_ptr_bin_sync - rd_ptr_bin_d;
        rd_almost_empty_d = (rd_count_d <= AE_LEVEL);
        rd_underflow_d    = bus.rd_en & bus.rd_empty;
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_bin_q      <= '0;
            rd_ptr_gray_q     <= '0;
            rd_count_q        <= '0;
            rd_almost_empty_q <= 1'b1;
            rd_underflow_q    <= 1'b0;
        end else begin
            rd_ptr_bin_q      <= rd_ptr_bin_d;
            rd_ptr_gray_q     <= rd_ptr_gray_d;
            rd_count_q        <= rd_count_d;
            rd_almost_empty_q <= rd_almost_empty_d;
            rd_underflow_q    <= rd_underflow_d;
        end
    end

    // Plain flop chain on the whole Gray bus; nothing may sit between stages.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= bus.wr_ptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign bus.rd_addr          = rd_ptr_bin_q[ADDR_WIDTH-1:0];
    assign bus.rd_ptr_gray      = rd_ptr_gray_q;
    assign bus.wr_ptr_gray_sync = sync_q[SYNC_STAGES-1];
    assign bus.rd_count         = rd_count_q;
    assign bus.rd_almost_empty  = rd_almost_empty_q;
    assign bus.rd_underflow     = rd_underflow_q;

endmodule

// File: tb/tb_fifo_rd_ptr.sv
// Directed bench for fifo_rd_ptr: a history-based reference model is compared every
// falling edge, and literal expectations pin the key scenarios.
module tb_fifo_rd_ptr;
    localparam int AW   = 4;
    localparam int SYNC = 2;
    localparam int AE   = 2;
    localparam int MOD  = 1 << (AW + 1);

    logic rd_clk;
    logic rst_n;
    int   checkCount = 0;
    int   failCount  = 0;

    fifo_rd_ptr_if #(.ADDR_WIDTH(AW)) bus ();

    fifo_rd_ptr #(
        .ADDR_WIDTH  (AW),
        .SYNC_STAGES (SYNC),
        .AE_THRESHOLD(AE)
    ) dut (
        .rd_clk(rd_clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        rd_clk = 1'b0;
        #3;
        forever #5 rd_clk = ~rd_clk;
    end

    function automatic logic [AW:0] toGray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the parity of all Gray bits at or above it.
    function automatic logic [AW:0] grayToBin(input logic [AW:0] g);
        logic [AW:0] b;
        for (int i = 0; i <= AW; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    // Reference model: count of accepted reads plus a log of sampled write pointers.
    int          modelRdPtr = 0;
    int          modelCount = 0;
    bit          modelAe    = 1'b1;
    bit          modelUf    = 1'b0;
    logic [AW:0] wrHist[$];

    function automatic logic [AW:0] expectedSync();
        if (wrHist.size() >= SYNC) return wrHist[wrHist.size() - SYNC];
        return '0;
    endfunction

    always @(posedge rd_clk or negedge rst_n) begin
        logic [AW:0] syncNow;
        if (!rst_n) begin
            modelRdPtr = 0;
            modelCount = 0;
            modelAe    = 1'b1;
            modelUf    = 1'b0;
            wrHist.delete();
        end else begin
            syncNow = expectedSync();
            modelUf = bus.rd_en && bus.rd_empty;
            if (bus.rd_en && !bus.rd_empty) modelRdPtr = (modelRdPtr + 1) % MOD;
            modelCount = (int'(grayToBin(syncNow)) - modelRdPtr + MOD) % MOD;
            modelAe    = (modelCount <= AE);
            wrHist.push_back(bus.wr_ptr_gray);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic empty, input logic [AW:0] wrg);
        bus.rd_en       = en;
        bus.rd_empty    = empty;
        bus.wr_ptr_gray = wrg;
    endtask

    task automatic stepCycle();
        @(posedge rd_clk);
        @(negedge rd_clk);
    endtask

    // Model comparison on every falling edge, away from the active edge.
    always @(negedge rd_clk) begin
        checkOutput("mdl_rd_addr",     int'(bus.rd_addr),          modelRdPtr % (1 << AW));
        checkOutput("mdl_rd_ptr_gray", int'(bus.rd_ptr_gray),      int'(toGray((AW+1)'(modelRdPtr))));
        checkOutput("mdl_wr_sync",     int'(bus.wr_ptr_gray_sync), int'(expectedSync()));
        checkOutput("mdl_rd_count",    int'(bus.rd_count),         modelCount);
        checkOutput("mdl_almost_empty", int'(bus.rd_almost_empty), int'(modelAe));
        checkOutput("mdl_underflow",   int'(bus.rd_underflow),     int'(modelUf));
    end

    initial begin
        applyStimulus(1'b0, 1'b1, '0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_rd_addr",      int'(bus.rd_addr),         0);
        checkOutput("rst_rd_ptr_gray",  int'(bus.rd_ptr_gray),     0);
        checkOutput("rst_rd_count",     int'(bus.rd_count),        0);
        checkOutput("rst_almost_empty", int'(bus.rd_almost_empty), 1);
        checkOutput("rst_underflow",    int'(bus.rd_underflow),    0);
        @(negedge rd_clk);
        rst_n = 1'b1;

        $display("[TB] synchronizer latency");
        applyStimulus(1'b0, 1'b1, 5'b00001);
        stepCycle();
        checkOutput("sync_edge1", int'(bus.wr_ptr_gray_sync), 0);
        stepCycle();
        checkOutput("sync_edge2", int'(bus.wr_ptr_gray_sync), 1);
        checkOutput("count_edge2", int'(bus.rd_count), 0);
        stepCycle();
        checkOutput("count_edge3", int'(bus.rd_count), 1);
        checkOutput("ae_edge3", int'(bus.rd_almost_empty), 1);

        $display("[TB] drain");
        applyStimulus(1'b0, 1'b0, 5'b00111);
        repeat (3) stepCycle();
        checkOutput("drain_count0", int'(bus.rd_count), 5);
        checkOutput("drain_ae0", int'(bus.rd_almost_empty), 0);
        checkOutput("drain_addr0", int'(bus.rd_addr), 0);
        applyStimulus(1'b1, 1'b0, 5'b00111);
        stepCycle();
        checkOutput("drain_addr1", int'(bus.rd_addr), 1);
        checkOutput("drain_count1", int'(bus.rd_count), 4);
        checkOutput("drain_ae1", int'(bus.rd_almost_empty), 0);
        stepCycle();
        checkOutput("drain_addr2", int'(bus.rd_addr), 2);
        checkOutput("drain_count2", int'(bus.rd_count), 3);
        stepCycle();
        checkOutput("drain_addr3", int'(bus.rd_addr), 3);
        checkOutput("drain_count3", int'(bus.rd_count), 2);
        checkOutput("drain_ae3", int'(bus.rd_almost_empty), 1);

        $display("[TB] underflow");
        applyStimulus(1'b1, 1'b1, 5'b00111);
        stepCycle();
        checkOutput("uf_pulse", int'(bus.rd_underflow), 1);
        checkOutput("uf_addr", int'(bus.rd_addr), 3);
        checkOutput("uf_gray", int'(bus.rd_ptr_gray), 5'b00010);
        applyStimulus(1'b0, 1'b0, 5'b00111);
        stepCycle();
        checkOutput("uf_clear", int'(bus.rd_underflow), 0);
        checkOutput("uf_addr_hold", int'(bus.rd_addr), 3);

        $display("[TB] wrap");
        for (int k = 0; k < 28; k++) begin
            applyStimulus(1'b1, 1'b0, toGray((AW+1)'(6 + k)));
            stepCycle();
        end
        applyStimulus(1'b0, 1'b0, toGray((AW+1)'(33)));
        stepCycle();
        checkOutput("wrap_addr_before", int'(bus.rd_addr), 15);
        checkOutput("wrap_gray_before", int'(bus.rd_ptr_gray), 5'b10000);
        applyStimulus(1'b1, 1'b0, toGray((AW+1)'(33)));
        stepCycle();
        checkOutput("wrap_addr_after", int'(bus.rd_addr), 0);
        checkOutput("wrap_gray_after", int'(bus.rd_ptr_gray), 5'b00000);

        $display("[TB] mid-stream reset");
        for (int w = 2; w <= 6; w++) begin
            applyStimulus(1'b0, 1'b0, toGray((AW+1)'(w)));
            stepCycle();
        end
        repeat (3) stepCycle();
        checkOutput("mid_count6", int'(bus.rd_count), 6);
        applyStimulus(1'b1, 1'b0, toGray((AW+1)'(6)));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_addr",  int'(bus.rd_addr),          0);
        checkOutput("mid_rst_gray",  int'(bus.rd_ptr_gray),      0);
        checkOutput("mid_rst_sync",  int'(bus.wr_ptr_gray_sync), 0);
        checkOutput("mid_rst_count", int'(bus.rd_count),         0);
        checkOutput("mid_rst_ae",    int'(bus.rd_almost_empty),  1);
        checkOutput("mid_rst_uf",    int'(bus.rd_underflow),     0);
        @(negedge rd_clk);
        @(negedge rd_clk);
        rst_n = 1'b1;
        #1;
        checkOutput("release_addr0", int'(bus.rd_addr), 0);
        stepCycle();
        checkOutput("release_addr1", int'(bus.rd_addr), 1);
        applyStimulus(1'b0, 1'b0, toGray((AW+1)'(6)));
        repeat (2) stepCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule

// File: doc/fifo_rd_ptr.md
FIFO_RD_PTR -- requirements
Module: fifo_rd_ptr

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, number of FIFO address bits (depth 2^ADDR_WIDTH).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, flop count in the write-pointer synchronizer (legal values 2..4).
REQ-003 SHALL have parameter AE_THRESHOLD, default 2, almost-empty threshold in entries.
REQ-004 SHALL have port rd_clk, input, 1, read-domain clock; one clock only.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port rd_en, input, 1, read request from the consumer.
REQ-007 SHALL have port rd_empty, input, 1, registered empty flag from the empty-detect stage.
REQ-008 SHALL have port wr_ptr_gray, input, ADDR_WIDTH+1, Gray write pointer, asynchronous to rd_clk.
REQ-009 SHALL have port rd_addr, output, ADDR_WIDTH, RAM read address.
REQ-010 SHALL have port rd_ptr_gray, output, ADDR_WIDTH+1, registered Gray read pointer, to the empty-detect stage and write domain.
REQ-011 SHALL have port wr_ptr_gray_sync, output, ADDR_WIDTH+1, write pointer after the synchronizer, to the empty-detect stage.
REQ-012 SHALL have port rd_count, output, ADDR_WIDTH+1, registered fill level seen from the read domain.
REQ-013 SHALL have port rd_almost_empty, output, 1, registered; high when rd_count <= AE_THRESHOLD.
REQ-014 SHALL have port rd_underflow, output, 1, registered one-cycle pulse on a rejected read.

Function
REQ-015 SHALL hold an internal binary read pointer rd_ptr_bin of ADDR_WIDTH+1 bits.
REQ-016 SHALL advance rd_ptr_bin by 1 on a rd_clk edge only when rd_en=1 and rd_empty=0; otherwise hold.
REQ-017 SHALL wrap rd_ptr_bin modulo 2^(ADDR_WIDTH+1), e.g. 31 -> 0 for ADDR_WIDTH=4.
REQ-018 SHALL register rd_ptr_gray as next_bin ^ (next_bin >> 1), on the same edge as rd_ptr_bin, so that both stay consistent.
REQ-019 SHALL drive rd_addr from rd_ptr_bin[ADDR_WIDTH-1:0], with no extra register stage.
REQ-020 SHALL pass wr_ptr_gray through SYNC_STAGES flops clocked by rd_clk, whole bus per stage, with no logic between stages.
REQ-021 SHALL reflect a change on wr_ptr_gray on wr_ptr_gray_sync exactly SYNC_STAGES rd_clk edges later.
REQ-022 SHALL convert wr_ptr_gray_sync to binary by prefix-XOR from the MSB.
REQ-023 SHALL register rd_count as (g2b(wr_ptr_gray_sync) - next_bin) modulo 2^(ADDR_WIDTH+1), using the next-state read pointer.
REQ-024 SHALL register rd_almost_empty from the same next-state count, with no extra lag relative to rd_count.
REQ-025 SHALL pulse rd_underflow high for exactly one cycle, on the edge after rd_en=1 with rd_empty=1; the pointer SHALL NOT move in that case.
REQ-026 SHALL produce the same rd_ptr_bin update on simultaneous rd_en and a synchronized write-pointer change as on the read alone; rd_count SHALL reflect both in the same cycle.
REQ-027 SHALL never let rd_count exceed 2^ADDR_WIDTH when its inputs come from a legal writer.

Reset
REQ-028 SHALL, while rst_n=0, immediately clear rd_ptr_bin, rd_addr, rd_ptr_gray, all synchronizer flops, wr_ptr_gray_sync, rd_count and rd_underflow to 0.
REQ-029 SHALL set rd_almost_empty to 1 during reset.
REQ-030 SHALL, on reset asserted mid-operation, take effect without a clock edge and discard any in-flight read.
REQ-031 SHALL resume normal operation on the first rd_clk edge after rst_n rises.

Verification
REQ-032 SHALL cover reset: with rst_n=0, rd_addr=0, rd_ptr_gray=0, rd_count=0, rd_almost_empty=1 and rd_underflow=0, checked before any clock.
REQ-033 SHALL cover synchronizer latency: with ADDR_WIDTH=4 and SYNC_STAGES=2, step wr_ptr_gray 00000->00001 -> wr_ptr_gray_sync=00001 after 2 edges; rd_count=1 one edge later; rd_almost_empty stays 1.
REQ-034 SHALL cover drain: with wr pointer bin 5 synced, rd_en=1 and rd_empty=0 for 3 cycles -> rd_addr 0,1,2,3; rd_count 5->2; rd_almost_empty rises on the edge where count reaches 2.
REQ-035 SHALL cover wrap: with rd_ptr_bin=31 and a read -> rd_ptr_bin=0, rd_ptr_gray 10000->00000, rd_addr 15->0.
REQ-036 SHALL cover underflow: rd_en=1 with rd_empty=1 -> rd_underflow pulses for 1 cycle; rd_addr and rd_ptr_gray are unchanged.
REQ-037 SHALL cover mid-stream reset: rst_n dropped during a read burst with rd_count=6 -> all outputs return to reset values asynchronously; rd_addr=0 on the first read after release.
